// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller: per-source stall masks, exception flush/redirect
// sequencing, and a stall-cycle counter with a sticky watchdog.
module pipe_ctrl_gen #(
   parameter int unsigned            STAGES        = 6,
   parameter int unsigned            NREQ          = 4,
   parameter logic [NREQ*4-1:0]      REQ_DEPTH     = {4'd3, 4'd2, 4'd1, 4'd1},
   parameter int unsigned            FLUSH_CYCLES  = 1,
   parameter logic [31:0]            EXC_VECTOR    = 32'hBFC0_0380,
   parameter logic [3:0]             RET_CODE      = 4'hE,
   parameter int unsigned            STALL_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic [3:0]        except_info,
   input  logic [31:0]       cp0_epc,
   output logic [STAGES-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              new_pc_valid,
   output logic              stall_timeout,
   output logic [31:0]       stall_cycles
);

   localparam int unsigned WD_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [3:0]        flush_cnt_q, flush_cnt_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic              new_pc_valid_q, new_pc_valid_d;
   logic              stall_timeout_q, stall_timeout_d;
   logic [31:0]       stall_cycles_q, stall_cycles_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [STAGES-1:0] stall_raw;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
      return (v == WD_LIMIT) ? v : v + 1'b1;
   endfunction

   // Each asserted source stalls stages 0..depth; deeper depths clip naturally.
   always_comb begin
      stall_raw = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         for (int s = 0; s < int'(STAGES); s++) begin
            if (stallreq[i] && (s <= int'(REQ_DEPTH[i*4 +: 4]))) begin
               stall_raw[s] = 1'b1;
            end
         end
      end
   end

   assign flush = (state_q == S_FLUSH);
   assign stall = (rst || flush) ? '0 : stall_raw;

   always_comb begin
      state_d        = state_q;
      flush_cnt_d    = flush_cnt_q;
      new_pc_d       = new_pc_q;
      new_pc_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (except_info != 4'h0) begin
               state_d        = S_FLUSH;
               flush_cnt_d    = 4'(FLUSH_CYCLES - 1);
               new_pc_d       = (except_info == RET_CODE) ? cp0_epc : EXC_VECTOR;
               new_pc_valid_d = 1'b1;
            end
         end
         S_FLUSH: begin
            // Exceptions arriving here, including on the exit edge, are dropped.
            if (flush_cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_cycles_d  = stall_cycles_q;
      wd_d            = '0;
      if (stall != '0) begin
         stall_cycles_d = sat_inc32(stall_cycles_q);
         wd_d           = sat_inc_wd(wd_q);
      end
      stall_timeout_d = stall_timeout_q | (wd_d == WD_LIMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         flush_cnt_q     <= 4'd0;
         new_pc_q        <= 32'd0;
         new_pc_valid_q  <= 1'b0;
         stall_timeout_q <= 1'b0;
         stall_cycles_q  <= 32'd0;
         wd_q            <= '0;
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         new_pc_q        <= new_pc_d;
         new_pc_valid_q  <= new_pc_valid_d;
         stall_timeout_q <= stall_timeout_d;
         stall_cycles_q  <= stall_cycles_d;
         wd_q            <= wd_d;
      end
   end

   assign new_pc        = new_pc_q;
   assign new_pc_valid  = new_pc_valid_q;
   assign stall_timeout = stall_timeout_q;
   assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: a default instance and one with
// FLUSH_CYCLES=3 / STALL_TIMEOUT=8, sharing the same stimulus.
module tb_pipe_ctrl_gen;

   logic        clk;
   logic        rst;
   logic [3:0]  stallreq;
   logic [3:0]  except_info;
   logic [31:0] cp0_epc;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b;
   logic [31:0] new_pc_a, new_pc_b;
   logic        npv_a, npv_b;
   logic        tmo_a, tmo_b;
   logic [31:0] cyc_a, cyc_b;

   int n_chk  = 0;
   int n_pass = 0;

   pipe_ctrl_gen dut_a (
      .clk(clk), .rst(rst), .stallreq(stallreq), .except_info(except_info),
      .cp0_epc(cp0_epc), .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
      .new_pc_valid(npv_a), .stall_timeout(tmo_a), .stall_cycles(cyc_a)
   );

   pipe_ctrl_gen #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .stallreq(stallreq), .except_info(except_info),
      .cp0_epc(cp0_epc), .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
      .new_pc_valid(npv_b), .stall_timeout(tmo_b), .stall_cycles(cyc_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stallreq = 4'b1111; except_info = 4'h0; cp0_epc = 32'h0;
      tick; tick;
      check("rst_stall", 32'(stall_a), 32'h0);
      check("rst_flush", 32'(flush_a), 32'h0);
      check("rst_new_pc", new_pc_a, 32'h0);
      check("rst_npv", 32'(npv_a), 32'h0);
      check("rst_tmo", 32'(tmo_b), 32'h0);
      check("rst_cycles", cyc_a, 32'h0);
      stallreq = 4'b0000;
      rst = 1'b0;

      stallreq = 4'b1000; #1; check("stall_src3", 32'(stall_a), 32'h0F);
      stallreq = 4'b0001; #1; check("stall_src0", 32'(stall_a), 32'h03);
      stallreq = 4'b0110; #1; check("stall_src12", 32'(stall_a), 32'h07);
      stallreq = 4'b0000; #1; check("stall_none", 32'(stall_a), 32'h00);
      tick;
      check("cycles_idle", cyc_a, 32'h0);

      except_info = 4'h4; cp0_epc = 32'h0000_1111;
      tick;
      except_info = 4'h0;
      check("exc_flush", 32'(flush_a), 32'h1);
      check("exc_npv", 32'(npv_a), 32'h1);
      check("exc_pc", new_pc_a, 32'hBFC0_0380);
      stallreq = 4'b1111; #1;
      check("flush_masks_stall", 32'(stall_a), 32'h0);
      stallreq = 4'b0000;
      tick;
      check("exc_flush_end", 32'(flush_a), 32'h0);
      check("exc_npv_end", 32'(npv_a), 32'h0);
      check("exc_pc_hold", new_pc_a, 32'hBFC0_0380);
      tick; tick;

      stallreq = 4'b0001; except_info = 4'h4; #1;
      check("simul_stall_now", 32'(stall_a), 32'h03);
      tick;
      except_info = 4'h0;
      check("simul_stall_next", 32'(stall_a), 32'h0);
      check("simul_cycles", cyc_a, 32'h1);
      stallreq = 4'b0000;
      tick; tick; tick; tick;

      cp0_epc = 32'h8000_1234; except_info = 4'hE;
      tick;
      except_info = 4'h8;
      check("ret_flush1", 32'(flush_b), 32'h1);
      check("ret_npv1", 32'(npv_b), 32'h1);
      check("ret_pc", new_pc_b, 32'h8000_1234);
      tick;
      check("ret_flush2", 32'(flush_b), 32'h1);
      check("ret_npv2", 32'(npv_b), 32'h0);
      tick;
      check("ret_flush3", 32'(flush_b), 32'h1);
      check("ret_npv3", 32'(npv_b), 32'h0);
      check("ret_pc_kept", new_pc_b, 32'h8000_1234);
      tick;
      except_info = 4'h0;
      check("ret_flush4", 32'(flush_b), 32'h0);
      check("ret_npv4", 32'(npv_b), 32'h0);
      check("ret_pc_after", new_pc_b, 32'h8000_1234);
      tick;
      check("no_queue_flush", 32'(flush_b), 32'h0);
      check("no_queue_npv", 32'(npv_b), 32'h0);

      except_info = 4'hE;
      tick;
      except_info = 4'h0;
      check("pre_rst_flush", 32'(flush_b), 32'h1);
      check("pre_rst_cycles", cyc_b, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_flush", 32'(flush_b), 32'h0);
      check("async_pc", new_pc_b, 32'h0);
      check("async_cycles", cyc_b, 32'h0);
      check("async_npv", 32'(npv_b), 32'h0);
      tick;
      rst = 1'b0;
      tick;
      check("post_rst_npv", 32'(npv_b), 32'h0);
      check("post_rst_flush", 32'(flush_b), 32'h0);
      tick;
      check("post_rst_npv2", 32'(npv_b), 32'h0);

      stallreq = 4'b0010;
      repeat (7) tick;
      check("wd_tmo_7", 32'(tmo_b), 32'h0);
      check("wd_cycles_7", cyc_b, 32'h7);
      tick;
      check("wd_tmo_8", 32'(tmo_b), 32'h1);
      check("wd_cycles_8", cyc_b, 32'h8);
      stallreq = 4'b0000;
      tick;
      check("wd_sticky", 32'(tmo_b), 32'h1);
      check("wd_cycles_hold", cyc_b, 32'h8);
      check("wd_default_quiet", 32'(tmo_a), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 Parameter STAGES, default 6: pipeline stage count, equal to the stall vector width.
REQ-002 Parameter NREQ, default 4: number of stall request sources.
REQ-003 Parameter REQ_DEPTH, default {4'd3,4'd2,4'd1,4'd1} (NREQ x 4 bits, source 0 in LSBs): highest stage index stalled by each source.
REQ-004 Parameter FLUSH_CYCLES, default 1, range 1..15: cycles flush stays high per exception.
REQ-005 Parameter EXC_VECTOR, default 32'hBFC0_0380: target PC for non-return exceptions.
REQ-006 Parameter RET_CODE, default 4'hE: exception code that selects the EPC target.
REQ-007 Parameter STALL_TIMEOUT, default 1024: consecutive stall cycles before the watchdog fires.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 stallreq  input  NREQ  per-source stall requests, level-sensitive.
REQ-011 except_info  input  4  exception code; 0 means none.
REQ-012 cp0_epc  input  32  return address used for RET_CODE.
REQ-013 stall  output  STAGES  per-stage stall mask; bit 0 is the fetch stage.
REQ-014 flush  output  1  registered pipeline flush.
REQ-015 new_pc  output  32  registered redirect target.
REQ-016 new_pc_valid  output  1  one-cycle pulse qualifying new_pc.
REQ-017 stall_timeout  output  1  sticky watchdog flag.
REQ-018 stall_cycles  output  32  saturating count of cycles with any stall bit set.

Function
REQ-019 Stall generation is combinational: stall = OR over each asserted source i of mask bits [0..REQ_DEPTH[i]], clipped to STAGES-1.
REQ-020 The FSM has two states, IDLE and FLUSH.
REQ-021 In IDLE, a nonzero except_info at a rising edge moves the FSM to FLUSH and loads flush_cnt with FLUSH_CYCLES-1.
REQ-022 On that same edge, new_pc is latched: cp0_epc if except_info==RET_CODE, otherwise EXC_VECTOR.
REQ-023 On that same edge, new_pc_valid is set to 1 for exactly one cycle.
REQ-024 In FLUSH, flush=1 and flush_cnt decrements by 1 per cycle.
REQ-025 In FLUSH, the FSM returns to IDLE on the edge where flush_cnt==0, so flush is high for exactly FLUSH_CYCLES cycles.
REQ-026 Latency: an exception sampled at edge n gives flush=1 and new_pc_valid=1 during cycle n+1.
REQ-027 Any except_info value present while in FLUSH is ignored and is not queued.
REQ-028 An exception present on the exit edge of FLUSH is also ignored; a new exception is accepted only in IDLE.
REQ-029 While flush=1, stall is forced to all zeros regardless of stallreq (flush has priority over stall).
REQ-030 new_pc holds its last value outside the new_pc_valid pulse.
REQ-031 stall_cycles increments each cycle in which stall is nonzero, saturates at 32'hFFFF_FFFF, and never wraps.
REQ-032 A watchdog counter increments while stall is nonzero and clears to 0 in any cycle where stall is zero.
REQ-033 When the watchdog counter reaches STALL_TIMEOUT, stall_timeout is set to 1 and stays 1 until reset.
REQ-034 The watchdog counter saturates at STALL_TIMEOUT.
REQ-035 Simultaneous stallreq and exception in IDLE: stall follows REQ-019 in the current cycle, and flush overrides stall from the next cycle on.

Reset
REQ-036 rst=1 asynchronously forces: state IDLE, flush=0, new_pc=0, new_pc_valid=0, stall_timeout=0, stall_cycles=0, watchdog=0, flush_cnt=0.
REQ-037 Reset asserted during FLUSH aborts the flush immediately; no redirect pulse occurs after reset is released.
REQ-038 stall remains combinational during reset, but is forced to 0 because state is IDLE and flush=0 with stallreq masked by rst.

Verification
REQ-039 Defaults, stallreq=4'b1000 then 4'b0001 -> stall=6'b001111, then 6'b000011; stallreq=0 -> 6'b000000.
REQ-040 except_info=4'h4 for one cycle -> next cycle flush=1, new_pc_valid=1, new_pc=32'hBFC0_0380; flush low the following cycle.
REQ-041 except_info=4'hE, cp0_epc=32'h8000_1234, FLUSH_CYCLES=3 -> flush high 3 cycles, new_pc=32'h8000_1234, new_pc_valid a single pulse.
REQ-042 Second exception (4'h8) during FLUSH with FLUSH_CYCLES=3 -> no second pulse; new_pc is unchanged.
REQ-043 STALL_TIMEOUT=8, stallreq=4'b0010 held 8 cycles -> stall_timeout=1 and stall_cycles=8; stall_timeout stays 1 after release.
REQ-044 rst pulsed mid-FLUSH -> flush=0, new_pc=0, and stall_cycles=0 immediately, without waiting for a clock edge.
